// File: rtl/tile_mm_pkg.sv
// Shared types and width helpers for the tile matrix-multiply engine.
// Contents:
//   state_e      - compute FSM states
//   host_sel_e   - host buffer select encodings
//   acc_width()  - accumulator width that cannot overflow over K_MAX products
//   addr_width() - host address width covering the largest buffer
package tile_mm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StWb   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SelA   = 2'd0,
        SelB   = 2'd1,
        SelC   = 2'd2,
        SelRsv = 2'd3
    } host_sel_e;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned kmax);
        return 2 * dw + $clog2(kmax) + 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned m, input int unsigned n,
                                               input int unsigned k);
        int unsigned mx;
        mx = m * k;
        if (k * n > mx) mx = k * n;
        if (m * n > mx) mx = m * n;
        return $clog2(mx);
    endfunction

endpackage

// File: rtl/mm_mac_sat.sv
// Registered signed multiply-accumulate with a combinational write-back stage.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clr_i        - clear accumulator (wins over en_i)
//   en_i         - accumulate a_i*b_i
//   a_i, b_i     - signed DW-bit operands
//   c_old_i      - current C element, added when accum_i is set
//   accum_i      - 1: result = c_old + acc; 0: result = acc
//   sat_i        - 1: saturate to signed CW range; 0: keep the low CW bits
//   result_o     - CW-bit value to write back into C
module mm_mac_sat #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 32,
    parameter int unsigned ACCW = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [CW-1:0] c_old_i,
    input  logic          accum_i,
    input  logic          sat_i,
    output logic [CW-1:0] result_o
);

    // One guard bit above the wider of acc and C so the accumulate add is exact.
    localparam int unsigned SW = ((ACCW > CW) ? ACCW : CW) + 1;

    localparam logic signed [SW-1:0] CMax = {{(SW - CW + 1){1'b0}}, {(CW - 1){1'b1}}};
    localparam logic signed [SW-1:0] CMin = {{(SW - CW + 1){1'b1}}, {(CW - 1){1'b0}}};

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [SW-1:0]   sum;

    always_comb begin
        prod  = $signed(a_i) * $signed(b_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACCW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        sum = SW'(acc_q);
        if (accum_i) begin
            sum = sum + SW'($signed(c_old_i));
        end
        result_o = sum[CW-1:0];
        if (sat_i) begin
            if (sum > CMax) begin
                result_o = CMax[CW-1:0];
            end else if (sum < CMin) begin
                result_o = CMin[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/tile_mm_engine.sv
// Runtime-configurable matrix-multiply tile engine: C = A*B or C += A*B.
// A, B, C live in internal buffers with fixed maximum strides
// (A[i][k] at i*K_MAX+k, B[k][j] at k*N_MAX+j, C[i][j] at i*N_MAX+j).
// Each C element takes cfg_k MAC cycles plus one write-back cycle.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   start_i, cfg_*_i              - compute request and tile configuration
//   busy_o, done_o, cfg_err_o     - status; done/cfg_err are one-cycle pulses
//   host_wr_en_i, host_rd_en_i    - host strobes
//   host_sel_i, host_addr_i       - buffer select (A/B/C) and word address
//   host_wr_data_i                - write data (A/B use the low DW bits)
//   host_rd_data_o, host_rd_valid_o - read data (A/B sign-extended), 1-cycle latency
//   host_wr_err_o                 - pulse on a dropped write
module tile_mm_engine
    import tile_mm_pkg::*;
#(
    parameter int unsigned M_MAX = 8,
    parameter int unsigned N_MAX = 8,
    parameter int unsigned K_MAX = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 32,
    localparam int unsigned AW   = addr_width(M_MAX, N_MAX, K_MAX),
    localparam int unsigned MW   = $clog2(M_MAX + 1),
    localparam int unsigned NW   = $clog2(N_MAX + 1),
    localparam int unsigned KW   = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [MW-1:0] cfg_m_i,
    input  logic [NW-1:0] cfg_n_i,
    input  logic [KW-1:0] cfg_k_i,
    input  logic          cfg_accum_i,
    input  logic          cfg_sat_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          cfg_err_o,
    input  logic          host_wr_en_i,
    input  logic          host_rd_en_i,
    input  logic [1:0]    host_sel_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [CW-1:0] host_wr_data_i,
    output logic [CW-1:0] host_rd_data_o,
    output logic          host_rd_valid_o,
    output logic          host_wr_err_o
);

    localparam int unsigned ASize = M_MAX * K_MAX;
    localparam int unsigned BSize = K_MAX * N_MAX;
    localparam int unsigned CSize = M_MAX * N_MAX;
    localparam int unsigned ACCW  = acc_width(DW, K_MAX);

    logic [DW-1:0] a_mem [ASize];
    logic [DW-1:0] b_mem [BSize];
    logic [CW-1:0] c_mem [CSize];

    state_e        state_q, state_d;
    logic [MW-1:0] i_q, i_d, m_q, m_d;
    logic [NW-1:0] j_q, j_d, n_q, n_d;
    logic [KW-1:0] k_q, k_d, kc_q, kc_d;
    logic          accum_q, accum_d, sat_q, sat_d;
    logic          done_q, done_d, cfg_err_q, cfg_err_d;
    logic          rd_valid_q, wr_err_q, wr_err_d;
    logic [CW-1:0] rd_data_q, rd_data_d;

    logic          cfg_ok, acc_clr, acc_en, c_we;
    logic          addr_ok, host_wr_ok;
    logic [AW-1:0] a_idx, b_idx, c_idx;
    logic [CW-1:0] mac_result;

    assign cfg_ok = (cfg_m_i != '0) && (32'(cfg_m_i) <= M_MAX) &&
                    (cfg_n_i != '0) && (32'(cfg_n_i) <= N_MAX) &&
                    (cfg_k_i != '0) && (32'(cfg_k_i) <= K_MAX);

    assign a_idx = AW'(i_q) * AW'(K_MAX) + AW'(k_q);
    assign b_idx = AW'(k_q) * AW'(N_MAX) + AW'(j_q);
    assign c_idx = AW'(i_q) * AW'(N_MAX) + AW'(j_q);

    mm_mac_sat #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (acc_clr),
        .en_i     (acc_en),
        .a_i      (a_mem[a_idx]),
        .b_i      (b_mem[b_idx]),
        .c_old_i  (c_mem[c_idx]),
        .accum_i  (accum_q),
        .sat_i    (sat_q),
        .result_o (mac_result)
    );

    // Compute FSM: next state, counters and pulses.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        m_d       = m_q;
        n_d       = n_q;
        kc_d      = kc_q;
        accum_d   = accum_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        c_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        m_d     = cfg_m_i;
                        n_d     = cfg_n_i;
                        kc_d    = cfg_k_i;
                        accum_d = cfg_accum_i;
                        sat_d   = cfg_sat_i;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_clr = 1'b1;
                        state_d = StMac;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StMac: begin
                acc_en = 1'b1;
                if (k_q == kc_q - KW'(1)) begin
                    state_d = StWb;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StWb: begin
                c_we    = 1'b1;
                acc_clr = 1'b1;
                k_d     = '0;
                state_d = StMac;
                if (j_q == n_q - NW'(1)) begin
                    j_d = '0;
                    if (i_q == m_q - MW'(1)) begin
                        i_d     = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        i_d = i_q + MW'(1);
                    end
                end else begin
                    j_d = j_q + NW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Host port decode and read mux.
    always_comb begin
        addr_ok   = 1'b0;
        rd_data_d = rd_data_q;
        case (host_sel_i)
            SelA:    addr_ok = 32'(host_addr_i) < ASize;
            SelB:    addr_ok = 32'(host_addr_i) < BSize;
            SelC:    addr_ok = 32'(host_addr_i) < CSize;
            default: addr_ok = 1'b0;
        endcase
        host_wr_ok = host_wr_en_i && (state_q == StIdle) && addr_ok;
        wr_err_d   = host_wr_en_i && !host_wr_ok;
        if (host_rd_en_i) begin
            rd_data_d = '0;
            if (addr_ok) begin
                case (host_sel_i)
                    SelA:    rd_data_d = CW'($signed(a_mem[host_addr_i]));
                    SelB:    rd_data_d = CW'($signed(b_mem[host_addr_i]));
                    SelC:    rd_data_d = c_mem[host_addr_i];
                    default: rd_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            m_q        <= '0;
            n_q        <= '0;
            kc_q       <= '0;
            accum_q    <= 1'b0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            m_q        <= m_d;
            n_q        <= n_d;
            kc_q       <= kc_d;
            accum_q    <= accum_d;
            sat_q      <= sat_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            rd_valid_q <= host_rd_en_i;
            rd_data_q  <= rd_data_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Buffers are not reset. Engine and host writes are exclusive by state.
    always_ff @(posedge clk) begin
        if (c_we) begin
            c_mem[c_idx] <= mac_result;
        end
        if (host_wr_ok) begin
            case (host_sel_i)
                SelA:    a_mem[host_addr_i] <= host_wr_data_i[DW-1:0];
                SelB:    b_mem[host_addr_i] <= host_wr_data_i[DW-1:0];
                SelC:    c_mem[host_addr_i] <= host_wr_data_i;
                default: ;
            endcase
        end
    end

    assign busy_o          = (state_q != StIdle);
    assign done_o          = done_q;
    assign cfg_err_o       = cfg_err_q;
    assign host_rd_data_o  = rd_data_q;
    assign host_rd_valid_o = rd_valid_q;
    assign host_wr_err_o   = wr_err_q;

endmodule

// File: tb/tb_tile_mm_engine.sv
// Self-checking bench for tile_mm_engine: reference A/B/C arrays, a C model,
// and a scoreboard queue of expected host read data.
module tb_tile_mm_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cfg_m = '0, cfg_n = '0, cfg_k = '0;
    logic        cfg_accum = 1'b0, cfg_sat = 1'b0;
    logic        busy, done, cfg_err;
    logic        host_wr_en = 1'b0, host_rd_en = 1'b0;
    logic [1:0]  host_sel = '0;
    logic [5:0]  host_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic [31:0] host_rd_data;
    logic        host_rd_valid, host_wr_err;

    int          n_total = 0;
    int          n_bad = 0;
    int          elapsed = 0;

    int          a_ref [64];
    int          b_ref [64];
    logic [31:0] c_ref [64];

    logic [31:0] exp_q [$];
    string       tag_q [$];

    tile_mm_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .cfg_m_i         (cfg_m),
        .cfg_n_i         (cfg_n),
        .cfg_k_i         (cfg_k),
        .cfg_accum_i     (cfg_accum),
        .cfg_sat_i       (cfg_sat),
        .busy_o          (busy),
        .done_o          (done),
        .cfg_err_o       (cfg_err),
        .host_wr_en_i    (host_wr_en),
        .host_rd_en_i    (host_rd_en),
        .host_sel_i      (host_sel),
        .host_addr_i     (host_addr),
        .host_wr_data_i  (host_wr_data),
        .host_rd_data_o  (host_rd_data),
        .host_rd_valid_o (host_rd_valid),
        .host_wr_err_o   (host_wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every returned read against the oldest expectation.
    always @(negedge clk) begin
        if (host_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), host_rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        elapsed++;
    endtask

    task automatic host_wr(input logic [1:0] sel, input int addr, input logic [31:0] data);
        host_wr_en   = 1'b1;
        host_sel     = sel;
        host_addr    = addr[5:0];
        host_wr_data = data;
        tick();
        host_wr_en = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] sel, input int addr, input logic [31:0] exp,
                           input string tag);
        exp_q.push_back(exp);
        tag_q.push_back($sformatf("%s[%0d]", tag, addr));
        host_rd_en = 1'b1;
        host_sel   = sel;
        host_addr  = addr[5:0];
        tick();
        host_rd_en = 1'b0;
    endtask

    task automatic wr_a(input int idx, input logic [31:0] v);
        host_wr(2'd0, idx, v);
        a_ref[idx] = int'($signed(v[15:0]));
    endtask

    task automatic wr_b(input int idx, input logic [31:0] v);
        host_wr(2'd1, idx, v);
        b_ref[idx] = int'($signed(v[15:0]));
    endtask

    task automatic read_all_c(input string tag);
        for (int x = 0; x < 64; x++) host_rd(2'd2, x, c_ref[x], tag);
    endtask

    // Reference model of one full compute run, 64-bit exact then clamp/wrap.
    task automatic model_run(input int m, input int n, input int k, input bit acc, input bit sat);
        longint s;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(a_ref[i*8+kk]) * longint'(b_ref[kk*8+j]);
                if (acc) s += longint'($signed(c_ref[i*8+j]));
                if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
                if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
                c_ref[i*8+j] = s[31:0];
            end
        end
    endtask

    task automatic start_op(input int m, input int n, input int k, input bit acc, input bit sat);
        cfg_m     = m[3:0];
        cfg_n     = n[3:0];
        cfg_k     = k[3:0];
        cfg_accum = acc;
        cfg_sat   = sat;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        elapsed = 0;
    endtask

    task automatic wait_done(input int lat, input string tag);
        while (!done && elapsed < lat + 50) tick();
        check({tag, "_latency"}, elapsed, lat);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run(input int m, input int n, input int k, input bit acc, input bit sat,
                       input string tag);
        model_run(m, n, k, acc, sat);
        start_op(m, n, k, acc, sat);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(m * n * (k + 1), tag);
    endtask

    task automatic cfg_err_case(input int m, input int n, input int k, input string tag);
        cfg_m = m[3:0];
        cfg_n = n[3:0];
        cfg_k = k[3:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_err"}, {31'd0, cfg_err}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_err_pulse"}, {31'd0, cfg_err}, 32'd0);
        check({tag, "_no_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_rd_valid", {31'd0, host_rd_valid}, 32'd0);
        check("rst_wr_err", {31'd0, host_wr_err}, 32'd0);
        check("rst_rd_data", host_rd_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic 2x3x4: A=1, B=2 -> 8 in region, rest of C keeps its pattern
        for (int x = 0; x < 64; x++) begin
            host_wr(2'd2, x, 32'hC0DE_0000 + x);
            c_ref[x] = 32'hC0DE_0000 + x;
        end
        for (int x = 0; x < 64; x++) wr_a(x, 32'd1);
        for (int x = 0; x < 64; x++) wr_b(x, 32'd2);
        run(2, 3, 4, 1'b0, 1'b0, "basic");
        check("basic_c00_model", c_ref[0], 32'd8);
        read_all_c("basic_c");

        // Signed 1x1x1, then accumulate
        wr_a(0, 32'hFFFF_FFFD);
        wr_b(0, 32'd7);
        host_rd(2'd0, 0, 32'hFFFF_FFFD, "a_sext");
        run(1, 1, 1, 1'b0, 1'b0, "signed");
        host_rd(2'd2, 0, 32'hFFFF_FFEB, "signed_c");
        run(1, 1, 1, 1'b1, 1'b0, "accum");
        host_rd(2'd2, 0, 32'hFFFF_FFD6, "accum_c");

        // Saturation vs wrap on 1x1x8 with max-positive operands
        for (int x = 0; x < 64; x++) wr_a(x, 32'd32767);
        for (int x = 0; x < 64; x++) wr_b(x, 32'd32767);
        run(1, 1, 8, 1'b0, 1'b1, "sat");
        host_rd(2'd2, 0, 32'h7FFF_FFFF, "sat_c");
        run(1, 1, 8, 1'b0, 1'b0, "wrap");
        host_rd(2'd2, 0, 32'hFFF8_0008, "wrap_c");

        // Rejected configurations leave C untouched
        cfg_err_case(1, 1, 0, "cfg_k0");
        cfg_err_case(9, 1, 1, "cfg_m9");
        host_rd(2'd2, 0, c_ref[0], "cfg_err_c");

        // Busy interlocks: dropped write and ignored restart
        model_run(2, 2, 3, 1'b0, 1'b0);
        start_op(2, 2, 3, 1'b0, 1'b0);
        host_wr_en   = 1'b1;
        host_sel     = 2'd0;
        host_addr    = '0;
        host_wr_data = 32'd5;
        tick();
        host_wr_en = 1'b0;
        check("busy_wr_err", {31'd0, host_wr_err}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_wr_err_pulse", {31'd0, host_wr_err}, 32'd0);
        wait_done(16, "interlock");
        host_rd(2'd0, 0, 32'h0000_7FFF, "interlock_a0");
        read_all_c("interlock_c");

        // Reserved select: write dropped, read returns zero
        host_wr(2'd3, 0, 32'h1234_5678);
        check("rsv_wr_err", {31'd0, host_wr_err}, 32'd1);
        host_rd(2'd3, 0, 32'd0, "rsv_rd");

        // Reset mid-operation, then a clean rerun
        for (int x = 0; x < 64; x++) wr_a(x, 32'(x - 20));
        for (int x = 0; x < 64; x++) wr_b(x, 32'(3 * x - 50));
        start_op(4, 4, 4, 1'b0, 1'b0);
        repeat (17) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run(4, 4, 4, 1'b0, 1'b0, "rerun");
        read_all_c("rerun_c");

        repeat (3) tick();
        check("sb_pending", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_mm_engine.md
Name: tile_mm_engine

Overview:
- Parametrised, runtime-configurable matrix-multiply tile engine: C = A×B, or C += A×B in accumulate mode.
- Internal A/B/C buffers are loaded and read by the host through a single-word port; compute runs sequentially with one signed MAC per cycle.
- Adds runtime tile dimensions, accumulate mode, saturation, error reporting and a busy/done handshake.
- Sits under the accelerator top as the compute unit fed by the CSR/host interface.

Parameters:
- M_MAX, 8, maximum rows of A/C
- N_MAX, 8, maximum columns of B/C
- K_MAX, 8, maximum inner dimension
- DW, 16, signed A/B element width
- CW, 32, signed C element width
- AW (localparam), $clog2(max(M_MAX*K_MAX, K_MAX*N_MAX, M_MAX*N_MAX)), host address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  compute request, sampled only in IDLE
- cfg_m  in  $clog2(M_MAX+1)  runtime rows
- cfg_n  in  $clog2(N_MAX+1)  runtime columns
- cfg_k  in  $clog2(K_MAX+1)  runtime inner dimension
- cfg_accum  in  1  1: C += A×B; 0: C = A×B
- cfg_sat  in  1  1: saturate C to CW signed range; 0: wrap
- busy  out  1  compute in progress
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle pulse on rejected start
- host_wr_en  in  1  host write strobe
- host_rd_en  in  1  host read strobe
- host_sel  in  2  buffer select: 0=A, 1=B, 2=C, 3=reserved
- host_addr  in  AW  word address
- host_wr_data  in  CW  write data; A/B take the low DW bits
- host_rd_data  out  CW  read data; A/B are sign-extended
- host_rd_valid  out  1  read data valid
- host_wr_err  out  1  one-cycle pulse on a dropped write

Behaviour:
- Buffer layout, fixed maximum strides:
  - A[i][k] at i*K_MAX+k
  - B[k][j] at k*N_MAX+j
  - C[i][j] at i*N_MAX+j
- Reset values: busy, done, cfg_err, host_rd_valid, host_wr_err, host_rd_data all 0; state IDLE; buffer contents not reset.
- States:
  - IDLE: start=1 with all cfg in 1..MAX → latch cfg, i=j=k=0, acc=0, go to MAC, busy=1 next cycle. start with any cfg of 0 or >MAX → cfg_err pulses next cycle, stays IDLE, no buffer change.
  - MAC: acc += A[i][k]*B[k][j] (signed DW×DW, acc width 2*DW+$clog2(K_MAX)+1); k++. When k==cfg_k-1 → WB.
  - WB: result = acc, or C[i][j]+acc (sign-extended) if cfg_accum; then saturate to [-2^(CW-1), 2^(CW-1)-1] if cfg_sat, else keep the low CW bits. Write C[i][j], clear acc, k=0. Advance j, wrapping j at cfg_n with i++. Last element (i=cfg_m-1, j=cfg_n-1) → IDLE with done=1, busy=0 at the same edge; otherwise → MAC.
- Latency: start accepted at edge t0; done high in the cycle after edge t0 + cfg_m*cfg_n*(cfg_k+1). done is high exactly one cycle.
- start while busy is ignored, with no error. start and the final WB in the same cycle: the start is ignored.
- Host writes:
  - While busy, or with address ≥ region size, or host_sel=3: dropped, host_wr_err pulses next cycle.
  - In IDLE, the write takes effect at the clock edge.
- Host reads:
  - Allowed at any time; 1-cycle latency; host_rd_valid pulses with the data.
  - Out-of-range address or host_sel=3 returns 0 with valid=1.
  - Reading C while busy returns the current contents.
  - host_rd_en and host_wr_en together at the same address return the old data.
- Reset mid-operation: immediate return to IDLE, all outputs 0; partially written C is left as-is; the next start behaves normally.

Decomposition:
- Package tile_mm_pkg holds:
  - state enum {IDLE, MAC, WB}
  - host_sel encodings
  - accumulator-width and address-width helper constants/functions
- One sub-module, mm_mac_sat:
  - registered signed MAC with clear
  - combinational accumulate-add plus saturate/wrap to CW

Test Plan:
- Basic: cfg 2/3/4, A all 1, B all 2 → every C[i][j]=8 over the valid 2×3 region; done exactly 30 edges after start; C outside the region unchanged.
- Signed: cfg 1/1/1, A[0]=-3, B[0]=7, accum=0 → C[0]=-21 (0xFFFFFFEB); done 2 edges after start. Rerun with accum=1 → C[0]=-42.
- Saturation: cfg 1/1/8, all A=B=32767. With sat=1 → C[0]=0x7FFFFFFF. With sat=0 → C[0]=0xFFF80008.
- Config error: cfg_k=0, then cfg_m=9, each with start → cfg_err one-cycle pulse each time, busy stays 0, no done, C unchanged.
- Busy interlocks: during compute, host write to A[0] → host_wr_err pulse and A[0] unchanged; extra start pulse → no restart, and done timing matches the original start.
- Reset mid-op: cfg 4/4/4 run, rst_n low at element 3 → busy=done=0 immediately; release, restart → correct full result and done timing.
